// File: rtl/seven_seg_capture.sv
// seven_seg_capture
//   Loopback monitor for a two-digit multiplexed 7-segment display. Watches the
//   active-low segment/anode bus, waits for each pattern to dwell unchanged for
//   SETTLE_CYCLES edges, decodes it back to hex and presents completed digit
//   pairs on a valid/ready port.
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   seg_n[6:0]   segments, active low, seg_n[0]=a .. seg_n[6]=g
//   an_n[1:0]    anodes, active low: 2'b10 digit0, 2'b01 digit1
//   out_ready    consumer accepts the pair when out_valid && out_ready
//   out_valid    a recovered pair is held on out_d1/out_d0
//   out_d0/out_d1 recovered hex digits
//   bad_pattern  one-cycle pulse: settled pattern not a hex glyph
//   overrun      one-cycle pulse: good capture dropped while a pair is pending
module seven_seg_capture #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_n,
  input  logic [1:0] an_n,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_d0,
  output logic [3:0] out_d1,
  output logic       bad_pattern,
  output logic       overrun
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE = CW'(SETTLE_CYCLES);

  typedef enum logic {COLLECT, PRESENT} state_t;

  // Returns {hit, hex}; hit=0 for anything outside the hex glyph set.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h10;
      7'b1111001: decode = 5'h11;
      7'b0100100: decode = 5'h12;
      7'b0110000: decode = 5'h13;
      7'b0011001: decode = 5'h14;
      7'b0010010: decode = 5'h15;
      7'b0000010: decode = 5'h16;
      7'b1111000: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0010000: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b0000011: decode = 5'h1B;
      7'b1000110: decode = 5'h1C;
      7'b0100001: decode = 5'h1D;
      7'b0000110: decode = 5'h1E;
      7'b0001110: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  state_t          state, state_nx;
  logic [1:0]      prev_an_p0;
  logic [6:0]      prev_seg_p0;
  logic [CW-1:0]   cnt_p0, cnt_nx;
  logic            done_p0, done_nx;
  logic [1:0]      got, got_nx;
  logic [3:0]      d0_r, d1_r, d0_nx, d1_nx;
  logic            sel_ok, same, cap, hit, apply;
  logic [3:0]      hex;
  logic [4:0]      dec;

  // Dwell tracking: decide on this edge whether the sample has settled
  always_comb begin
    sel_ok = (an_n == 2'b10) || (an_n == 2'b01);
    same   = (an_n == prev_an_p0) && (seg_n == prev_seg_p0);
    cnt_nx = '0;
    if (sel_ok) begin
      if (same) cnt_nx = (cnt_p0 == SETTLE) ? SETTLE : cnt_p0 + 1'b1;
      else      cnt_nx = {{(CW-1){1'b0}}, 1'b1};
    end
    // The done flag survives only while the same valid sample keeps dwelling,
    // so a saturated counter cannot re-trigger a capture.
    cap     = sel_ok && (cnt_nx == SETTLE) && !(same && done_p0);
    done_nx = cap || (sel_ok && same && done_p0);
    dec     = decode(seg_n);
    hit     = dec[4];
    hex     = dec[3:0];
    // In PRESENT a good capture only lands if the pending pair leaves this edge.
    apply   = cap && hit && ((state == COLLECT) || out_ready);
    got_nx  = got;
    d0_nx   = d0_r;
    d1_nx   = d1_r;
    if (apply) begin
      if (an_n == 2'b10) begin
        got_nx[0] = 1'b1;
        d0_nx     = hex;
      end else begin
        got_nx[1] = 1'b1;
        d1_nx     = hex;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      COLLECT: if (got_nx == 2'b11) state_nx = PRESENT;
      PRESENT: if (out_ready)       state_nx = COLLECT;
      default:                      state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= COLLECT;
    else       state <= state_nx;
  end

  // Registered sample, dwell state and collection/presentation registers
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_an_p0  <= '0;
      prev_seg_p0 <= '0;
      cnt_p0      <= '0;
      done_p0     <= 1'b0;
      got         <= '0;
      d0_r        <= '0;
      d1_r        <= '0;
      out_valid   <= 1'b0;
      out_d0      <= '0;
      out_d1      <= '0;
      bad_pattern <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      prev_an_p0  <= an_n;
      prev_seg_p0 <= seg_n;
      cnt_p0      <= cnt_nx;
      done_p0     <= done_nx;
      d0_r        <= d0_nx;
      d1_r        <= d1_nx;
      bad_pattern <= cap && !hit;
      overrun     <= cap && hit && (state == PRESENT) && !out_ready;
      got         <= got_nx;
      if (state == COLLECT) begin
        if (got_nx == 2'b11) begin
          out_d0    <= d0_nx;
          out_d1    <= d1_nx;
          out_valid <= 1'b1;
          got       <= '0;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
module tb_seven_seg_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_d0;
  logic [3:0] out_d1;
  logic       bad_pattern;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int bp_cnt = 0;
  int ov_cnt = 0;

  logic [6:0] glyph [16];

  seven_seg_capture #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .seg_n(seg_n), .an_n(an_n),
    .out_ready(out_ready), .out_valid(out_valid), .out_d0(out_d0),
    .out_d1(out_d1), .bad_pattern(bad_pattern), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bad_pattern === 1'b1) bp_cnt++;
    if (overrun === 1'b1)     ov_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic show(input logic [1:0] a, input logic [6:0] s, input int n);
    an_n  = a;
    seg_n = s;
    step(n);
  endtask

  initial begin
    glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100;
    glyph[3]  = 7'b0110000; glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010;
    glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000; glyph[8]  = 7'b0000000;
    glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
    glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110;
    glyph[15] = 7'b0001110;

    reset = 1'b1; seg_n = 7'h7F; an_n = 2'b11; out_ready = 1'b0;
    step(2);
    check("rst_valid", {7'd0, out_valid}, 8'd0);
    check("rst_d0", {4'd0, out_d0}, 8'd0);
    check("rst_d1", {4'd0, out_d1}, 8'd0);
    check("rst_bad", {7'd0, bad_pattern}, 8'd0);
    check("rst_ovr", {7'd0, overrun}, 8'd0);
    reset = 1'b0;

    // Basic pair: 2 on digit0, F on digit1
    show(2'b10, 7'b0100100, 4);
    check("basic_not_yet", {7'd0, out_valid}, 8'd0);
    show(2'b01, 7'b0001110, 4);
    check("basic_valid", {7'd0, out_valid}, 8'd1);
    check("basic_d0", {4'd0, out_d0}, 8'h2);
    check("basic_d1", {4'd0, out_d1}, 8'hF);
    check("basic_nobad", bp_cnt[7:0], 8'd0);

    // Backpressure: new digit0 capture while pair pending
    show(2'b10, 7'b0010010, 4);
    check("bp_ovr_pulse", {7'd0, overrun}, 8'd1);
    check("bp_hold_valid", {7'd0, out_valid}, 8'd1);
    check("bp_hold_d0", {4'd0, out_d0}, 8'h2);
    check("bp_hold_d1", {4'd0, out_d1}, 8'hF);
    step(3);
    check("bp_ovr_once", ov_cnt[7:0], 8'd1);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("bp_accept", {7'd0, out_valid}, 8'd0);

    // Glitch: 3-cycle dwell must not capture; dropped capture above must not count
    show(2'b10, 7'b1111001, 3);
    show(2'b11, 7'b1111111, 2);
    show(2'b01, 7'b1111000, 4);
    check("glitch_novalid", {7'd0, out_valid}, 8'd0);

    // Blank pattern held 6 cycles: one bad_pattern pulse
    show(2'b10, 7'b1111111, 4);
    check("bad_pulse", {7'd0, bad_pattern}, 8'd1);
    step(2);
    check("bad_once", bp_cnt[7:0], 8'd1);
    check("bad_cleared", {7'd0, bad_pattern}, 8'd0);
    check("bad_novalid", {7'd0, out_valid}, 8'd0);

    // Invalid selects never capture
    show(2'b00, 7'b0000000, 8);
    show(2'b11, 7'b1000000, 8);
    check("sel_novalid", {7'd0, out_valid}, 8'd0);

    // Reset mid-dwell, then only 3 further cycles: no digit0 capture
    show(2'b10, 7'b0110000, 3);
    reset = 1'b1; step(1); reset = 1'b0;
    step(3);
    show(2'b01, 7'b1111000, 4);
    check("rst3_novalid", {7'd0, out_valid}, 8'd0);

    // Reset mid-dwell, then 4 further cycles: capture
    show(2'b10, 7'b0110000, 3);
    reset = 1'b1; step(1); reset = 1'b0;
    step(4);
    show(2'b01, 7'b1111000, 4);
    check("rst4_valid", {7'd0, out_valid}, 8'd1);
    check("rst4_d0", {4'd0, out_d0}, 8'h3);
    check("rst4_d1", {4'd0, out_d1}, 8'h7);
    out_ready = 1'b1; step(1); out_ready = 1'b0;
    check("rst4_accept", {7'd0, out_valid}, 8'd0);

    // Table sweep on digit0 with digit1 fixed at 7
    for (int i = 0; i < 16; i++) begin
      show(2'b10, glyph[i], 4);
      show(2'b01, 7'b1111000, 4);
      check($sformatf("sweep%0d_valid", i), {7'd0, out_valid}, 8'd1);
      check($sformatf("sweep%0d_d0", i), {4'd0, out_d0}, 8'(i));
      check($sformatf("sweep%0d_d1", i), {4'd0, out_d1}, 8'h7);
      out_ready = 1'b1; step(1); out_ready = 1'b0;
      check($sformatf("sweep%0d_acc", i), {7'd0, out_valid}, 8'd0);
    end

    check("final_bad_cnt", bp_cnt[7:0], 8'd1);
    check("final_ovr_cnt", ov_cnt[7:0], 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
